// File: rtl/system_widths_pkg.sv
// Shared widths and arbiter state encoding for the MIU-to-cache path.
// No logic; constants and types only.
// Not applicable: no flow control here.
package system_widths_pkg;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int ADDR_W_DEFAULT  = 16;
  localparam int DATA_W_DEFAULT  = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner search: first set req bit at or after rr_ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is consumed.
module rr_arbiter #(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  logic [IDX_W:0] cand;

  // Walk the requesters starting at rr_ptr; the first hit locks the result.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!any_req && req[cand[IDX_W-1:0]]) begin
        winner  = cand[IDX_W-1:0];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ MIU requesters onto one cache port.
// Latency: req_valid in cycle 0 -> cache_req_valid in cycle 1; 3 cycles minimum per transaction.
// Backpressure: only the owner sees req_ready, mirroring cache_req_ready; one transaction in flight.
module cache_arbiter
  import system_widths_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_write,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [DATA_W-1:0]               resp_data,
  output logic                            cache_req_valid,
  input  logic                            cache_req_ready,
  output logic                            cache_req_we,
  output logic [ADDR_W-1:0]               cache_req_addr,
  output logic [DATA_W-1:0]               cache_req_write,
  input  logic                            cache_resp_valid,
  input  logic [DATA_W-1:0]               cache_resp_data,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic [IDX_W:0]   owner_sum;
  logic [IDX_W-1:0] owner_inc;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Pointer for the next search: one past the owner, wrapping at NUM_REQ.
  assign owner_sum = {1'b0, owner} + (IDX_W+1)'(1);
  assign owner_inc = (owner_sum == (IDX_W+1)'(NUM_REQ)) ? '0 : owner_sum[IDX_W-1:0];

  // All arbiter state; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Next-state and output decode; every output is zero unless its state drives it.
  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    rr_ptr_nxt      = rr_ptr;
    cache_req_valid = 1'b0;
    cache_req_we    = 1'b0;
    cache_req_addr  = '0;
    cache_req_write = '0;
    req_ready       = '0;
    resp_valid      = '0;
    resp_data       = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          owner_nxt = winner;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Fields come straight from the owner, which must hold them until accepted.
        cache_req_valid  = req_valid[owner];
        cache_req_we     = req_we[owner];
        cache_req_addr   = req_addr[owner];
        cache_req_write  = req_write[owner];
        req_ready[owner] = cache_req_ready;
        if (req_valid[owner]) begin
          if (cache_req_ready) begin
            state_nxt  = WAIT_RESP;
            rr_ptr_nxt = owner_inc;
          end
        end else begin
          // Owner withdrew its request: drop the grant without touching fairness.
          state_nxt = IDLE;
        end
      end
      WAIT_RESP: begin
        resp_valid[owner] = cache_resp_valid;
        resp_data         = cache_resp_data;
        if (cache_resp_valid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign grant_id = owner;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a queue-based scoreboard.
// A behavioural cache answers handshakes after a programmable delay.
// A negedge monitor pops expected requests/responses whenever the DUT presents them.
module tb_cache_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic                  clk = 1'b0;
  logic                  resetN;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N-1:0]          req_we;
  logic [N-1:0][AW-1:0]  req_addr;
  logic [N-1:0][DW-1:0]  req_write;
  logic [N-1:0]          resp_valid;
  logic [DW-1:0]         resp_data;
  logic                  cache_req_valid;
  logic                  cache_req_ready;
  logic                  cache_req_we;
  logic [AW-1:0]         cache_req_addr;
  logic [DW-1:0]         cache_req_write;
  logic                  cache_resp_valid;
  logic [DW-1:0]         cache_resp_data;
  logic [1:0]            grant_id;
  logic                  busy;

  always #5 clk = ~clk;

  cache_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk              (clk),
    .resetN           (resetN),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_write        (req_write),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .cache_req_valid  (cache_req_valid),
    .cache_req_ready  (cache_req_ready),
    .cache_req_we     (cache_req_we),
    .cache_req_addr   (cache_req_addr),
    .cache_req_write  (cache_req_write),
    .cache_resp_valid (cache_resp_valid),
    .cache_resp_data  (cache_resp_data),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  typedef struct {
    logic [1:0]  id;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } exp_req_t;

  typedef struct {
    logic [3:0]  vec;
    logic [31:0] data;
  } exp_resp_t;

  exp_req_t  exp_req_q[$];
  exp_resp_t exp_resp_q[$];

  int checks = 0;
  int errors = 0;

  // Cache model / requester bookkeeping
  logic        model_en;
  int          resp_delay;
  int          stall;
  logic        pend;
  int          dly;
  logic [31:0] pdata;
  int          cnt[N];
  int          used;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] cache_data(input logic [15:0] a);
    return (a == 16'h0040) ? 32'hDEADBEEF : {16'hC0DE, a};
  endfunction

  // One clock cycle: requesters retire accepted requests, the cache model reacts.
  task automatic step();
    logic        hs;
    logic [15:0] hs_addr;
    logic [3:0]  consumed;
    #1;
    hs       = cache_req_valid && cache_req_ready;
    hs_addr  = cache_req_addr;
    consumed = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (consumed[i]) cnt[i]--;
      req_valid[i] = (cnt[i] > 0);
    end
    #1;
    if (model_en) begin
      cache_resp_valid = 1'b0;
      if (hs) begin
        pend  = 1'b1;
        dly   = resp_delay;
        pdata = cache_data(hs_addr);
      end
      if (pend) begin
        if (dly == 0) begin
          cache_resp_valid = 1'b1;
          cache_resp_data  = pdata;
          pend             = 1'b0;
        end else begin
          dly--;
        end
      end
      if (cache_req_valid) begin
        if (stall > 0) begin
          cache_req_ready = 1'b0;
          stall--;
        end else begin
          cache_req_ready = 1'b1;
        end
      end else begin
        cache_req_ready = 1'b0;
      end
    end
    #1;
  endtask

  task automatic issue(input int i, input int n, input logic we, input logic [15:0] a,
                       input logic [31:0] d);
    req_we[i]    = we;
    req_addr[i]  = a;
    req_write[i] = d;
    cnt[i]       = n;
    req_valid[i] = 1'b1;
  endtask

  task automatic run_idle(input int maxc, output int steps);
    steps = 0;
    while ((busy || req_valid != '0) && steps < maxc) begin
      step();
      steps++;
    end
    chk("drain_timeout", {63'd0, busy}, 64'd0);
  endtask

  // Scoreboard monitor
  initial begin
    exp_req_t  e;
    exp_resp_t r;
    forever begin
      @(negedge clk);
      if (resetN) begin
        if (cache_req_valid && cache_req_ready) begin
          chk("req_expected", {63'd0, exp_req_q.size() != 0}, 64'd1);
          if (exp_req_q.size() != 0) begin
            e = exp_req_q.pop_front();
            chk("req_id", grant_id, e.id);
            chk("req_fields", {cache_req_we, cache_req_addr, cache_req_write},
                {e.we, e.addr, e.wdata});
          end
        end
        if (resp_valid != '0) begin
          chk("resp_expected", {63'd0, exp_resp_q.size() != 0}, 64'd1);
          if (exp_resp_q.size() != 0) begin
            r = exp_resp_q.pop_front();
            chk("resp_vec", resp_valid, r.vec);
            chk("resp_data", resp_data, r.data);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Stimulus
  initial begin
    resetN           = 1'b0;
    req_valid        = '0;
    req_we           = '0;
    req_addr         = '0;
    req_write        = '0;
    cache_req_ready  = 1'b0;
    cache_resp_valid = 1'b0;
    cache_resp_data  = '0;
    model_en         = 1'b1;
    resp_delay       = 0;
    stall            = 0;
    pend             = 1'b0;
    dly              = 0;
    pdata            = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;

    // Reset state
    #1;
    chk("rst_req", {cache_req_valid, req_ready, resp_valid}, 64'd0);
    chk("rst_data", {resp_data, cache_req_addr}, 64'd0);
    chk("rst_grant_busy", {grant_id, busy}, 64'd0);
    step();
    step();
    resetN = 1'b1;
    step();

    // All four requesters continuously valid, 1-cycle response
    resp_delay = 0;
    exp_req_q.push_back('{2'd0, 1'b0, 16'h1000, 32'hB0000000});
    exp_req_q.push_back('{2'd1, 1'b1, 16'h1010, 32'hB0000001});
    exp_req_q.push_back('{2'd2, 1'b0, 16'h1020, 32'hB0000002});
    exp_req_q.push_back('{2'd3, 1'b1, 16'h1030, 32'hB0000003});
    exp_req_q.push_back('{2'd0, 1'b0, 16'h1000, 32'hB0000000});
    exp_resp_q.push_back('{4'b0001, 32'hC0DE1000});
    exp_resp_q.push_back('{4'b0010, 32'hC0DE1010});
    exp_resp_q.push_back('{4'b0100, 32'hC0DE1020});
    exp_resp_q.push_back('{4'b1000, 32'hC0DE1030});
    exp_resp_q.push_back('{4'b0001, 32'hC0DE1000});
    issue(0, 2, 1'b0, 16'h1000, 32'hB0000000);
    issue(1, 1, 1'b1, 16'h1010, 32'hB0000001);
    issue(2, 1, 1'b0, 16'h1020, 32'hB0000002);
    issue(3, 1, 1'b1, 16'h1030, 32'hB0000003);
    run_idle(40, used);
    chk("rr_all_cycles", used, 15);

    // Single read from requester 2, response two cycles after handshake
    resp_delay = 1;
    exp_req_q.push_back('{2'd2, 1'b0, 16'h0040, 32'h11111111});
    exp_resp_q.push_back('{4'b0100, 32'hDEADBEEF});
    issue(2, 1, 1'b0, 16'h0040, 32'h11111111);
    step();
    chk("rd_issue", {cache_req_valid, cache_req_addr, req_ready, grant_id},
        {1'b1, 16'h0040, 4'b0100, 2'd2});
    step();
    chk("rd_wait", {resp_valid, busy}, {4'b0000, 1'b1});
    step();
    chk("rd_resp", {resp_valid, resp_data}, {4'b0100, 32'hDEADBEEF});
    step();
    chk("rd_done", {63'd0, busy}, 64'd0);

    // rr_ptr is now 3: requesters 0 and 2 -> grant 0 then 2
    resp_delay = 0;
    exp_req_q.push_back('{2'd0, 1'b1, 16'h0100, 32'hA0A0A0A0});
    exp_req_q.push_back('{2'd2, 1'b0, 16'h0200, 32'h0B0B0B0B});
    exp_resp_q.push_back('{4'b0001, 32'hC0DE0100});
    exp_resp_q.push_back('{4'b0100, 32'hC0DE0200});
    issue(0, 1, 1'b1, 16'h0100, 32'hA0A0A0A0);
    issue(2, 1, 1'b0, 16'h0200, 32'h0B0B0B0B);
    step();
    chk("wrap_first_grant", grant_id, 2'd0);
    run_idle(20, used);
    chk("wrap_cycles", used, 5);

    // Backpressure on requester 1 for 5 cycles
    stall = 5;
    exp_req_q.push_back('{2'd1, 1'b1, 16'h0ABC, 32'h12345678});
    exp_resp_q.push_back('{4'b0010, 32'hC0DE0ABC});
    issue(1, 1, 1'b1, 16'h0ABC, 32'h12345678);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("stall_hold_%0d", k),
          {cache_req_valid, cache_req_we, cache_req_addr, cache_req_write, req_ready},
          {1'b1, 1'b1, 16'h0ABC, 32'h12345678, 4'b0000});
    end
    step();
    chk("stall_ready", {cache_req_addr, req_ready}, {16'h0ABC, 4'b0010});
    run_idle(20, used);

    // Spurious cache response while idle
    model_en         = 1'b0;
    cache_resp_valid = 1'b1;
    cache_resp_data  = 32'h5A5A5A5A;
    #1;
    chk("spur_now", {resp_valid, busy}, 64'd0);
    step();
    chk("spur_next", {resp_valid, busy}, 64'd0);
    cache_resp_valid = 1'b0;
    model_en         = 1'b1;

    // Reset in WAIT_RESP, late response must be dropped
    resp_delay = 3;
    exp_req_q.push_back('{2'd3, 1'b0, 16'h0333, 32'h33333333});
    issue(3, 1, 1'b0, 16'h0333, 32'h33333333);
    step();
    step();
    chk("mid_wait", {grant_id, busy}, {2'd3, 1'b1});
    resetN = 1'b0;
    #1;
    chk("mid_rst_out", {busy, grant_id, resp_valid, cache_req_valid, resp_data},
        64'd0);
    model_en         = 1'b0;
    pend             = 1'b0;
    cache_req_ready  = 1'b0;
    cache_resp_valid = 1'b0;
    step();
    resetN           = 1'b1;
    cache_resp_valid = 1'b1;
    cache_resp_data  = 32'hFEEDF00D;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_rst_%0d", k), {resp_valid, busy, grant_id}, 64'd0);
    end
    cache_resp_valid = 1'b0;
    model_en         = 1'b1;
    step();

    chk("req_q_empty", exp_req_q.size(), 0);
    chk("resp_q_empty", exp_resp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of MIU requesters (2..8).
REQ-002 Parameter ADDR_W, default 16, request address width.
REQ-003 Parameter DATA_W, default 32, write/response data width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 resetN  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  NUM_REQ  per-requester request valid.
REQ-008 req_ready  output  NUM_REQ  per-requester request accepted.
REQ-009 req_we  input  NUM_REQ  per-requester write enable (1=write, 0=read).
REQ-010 req_addr  input  NUM_REQ x ADDR_W  per-requester address.
REQ-011 req_write  input  NUM_REQ x DATA_W  per-requester write data.
REQ-012 resp_valid  output  NUM_REQ  per-requester response valid.
REQ-013 resp_data  output  DATA_W  response data, common to all requesters.
REQ-014 cache_req_valid  output  1  request to cache.
REQ-015 cache_req_ready  input  1  cache accepts request.
REQ-016 cache_req_we / cache_req_addr / cache_req_write  output  1 / ADDR_W / DATA_W  forwarded request fields.
REQ-017 cache_resp_valid  input  1  cache response valid; cache_resp_data  input  DATA_W  response data.
REQ-018 grant_id  output  clog2(NUM_REQ)  current owner; busy  output  1  state != IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE and WAIT_RESP, with exactly one cache transaction outstanding at a time.
REQ-020 IDLE: if any req_valid is set, latch the round-robin winner into owner and go to ISSUE next cycle; otherwise stay in IDLE.
REQ-021 Round-robin: search starts at rr_ptr and wraps from NUM_REQ-1 to 0; the first set req_valid bit wins.
REQ-022 ISSUE: cache_req_valid = req_valid[owner]; the cache_req_* fields SHALL be the owner's fields, stable for the whole state.
REQ-023 ISSUE: req_ready[owner] = cache_req_ready; every other req_ready bit is 0.
REQ-024 ISSUE handshake (req_valid[owner] && cache_req_ready): go to WAIT_RESP and set rr_ptr = (owner+1) mod NUM_REQ.
REQ-025 ISSUE with req_valid[owner] deasserted (protocol violation): return to IDLE with no cache request and rr_ptr unchanged.
REQ-026 WAIT_RESP: resp_valid[owner] = cache_resp_valid and resp_data = cache_resp_data; on cache_resp_valid, go to IDLE.
REQ-027 cache_resp_valid outside WAIT_RESP SHALL be ignored: no resp_valid bit asserts.
REQ-028 Outside ISSUE, cache_req_valid and all req_ready bits are 0; outside WAIT_RESP, all resp_valid bits are 0.
REQ-029 Minimum latency: req_valid asserted in cycle 0 gives cache_req_valid in cycle 1 and the earliest handshake in cycle 1.
REQ-030 Minimum occupancy is 3 cycles per transaction (IDLE, ISSUE, WAIT_RESP); the next grant is evaluated in the cycle after the response.
REQ-031 No requester SHALL wait more than NUM_REQ-1 grants while holding req_valid.

Reset
REQ-032 On resetN low (async), state = IDLE, owner = 0, rr_ptr = 0, and all outputs = 0, including resp_data and grant_id.
REQ-033 Reset mid-transaction SHALL abandon the transaction; after release no stale resp_valid is delivered.

Structure
REQ-034 ADDR_W and DATA_W defaults SHALL live in system_widths_pkg, together with typedef arb_state_t {IDLE, ISSUE, WAIT_RESP}.
REQ-035 The winner search SHALL be a combinational sub-module rr_arbiter (inputs: req vector, rr_ptr; outputs: winner index, any_req).
REQ-036 All state (state, owner, rr_ptr) SHALL be held in a single always_ff block with async reset.

Verification
REQ-037 Single read: req_valid[2]=1, we=0, addr=0x0040; cache ready in cycle 1 and responds 0xDEADBEEF two cycles later -> cache_req_addr=0x0040, resp_valid[2] pulses with 0xDEADBEEF, other resp_valid bits stay 0.
REQ-038 All four requesters valid continuously with cache ready and 1-cycle response -> grants in order 0,1,2,3,0; each grant occupies 3 cycles.
REQ-039 Backpressure: cache_req_ready=0 for 5 cycles during ISSUE of requester 1 -> cache_req_addr/write/we stable, req_ready[1] asserts only in the ready cycle.
REQ-040 rr_ptr=3 with req_valid=4'b0101 -> grant_id=0, then 2.
REQ-041 Spurious cache_resp_valid in IDLE -> resp_valid=0 on all bits, state stays IDLE.
REQ-042 resetN pulsed low in WAIT_RESP, cache_resp_valid=1 after release -> no resp_valid asserts, busy=0, grant_id=0.
